// File: rtl/exmem_skid_stage_if.sv
// Handshake and bus bundle between a pipeline stage and its neighbours.
// The slave view belongs to the stage; the master view belongs to the surrounding pipeline.
interface exmem_skid_stage_if #(
    parameter int CTRL_W = 6,
    parameter int DATA_W = 262,
    parameter int CNT_W  = 16
);
    logic              in_valid;
    logic              in_ready;
    logic [CTRL_W-1:0] in_ctrl;
    logic [DATA_W-1:0] in_data;
    logic              flush;
    logic              out_valid;
    logic              out_ready;
    logic [CTRL_W-1:0] out_ctrl;
    logic [DATA_W-1:0] out_data;
    logic [1:0]        occupancy;
    logic [CNT_W-1:0]  stall_cnt;

    // Valid/ready: a transfer happens on a rising edge where valid and ready are both high;
    // the producer holds valid and its payload stable until that edge, and ready never
    // depends combinationally on valid.
    modport master (
        output in_valid, in_ctrl, in_data, flush, out_ready,
        input  in_ready, out_valid, out_ctrl, out_data, occupancy, stall_cnt
    );

    modport slave (
        input  in_valid, in_ctrl, in_data, flush, out_ready,
        output in_ready, out_valid, out_ctrl, out_data, occupancy, stall_cnt
    );
endinterface

// File: rtl/exmem_skid_stage.sv
// Pipeline-stage register with a two-entry skid buffer, synchronous flush,
// bubble-gated control output and a saturating downstream-stall counter.
module exmem_skid_stage #(
    parameter int CTRL_W = 6,
    parameter int DATA_W = 262,
    parameter int CNT_W  = 16
) (
    input  logic                clk,
    input  logic                reset,
    exmem_skid_stage_if.slave   pipe_if
);
    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    logic              h_valid_q, h_valid_d;
    logic [CTRL_W-1:0] h_ctrl_q,  h_ctrl_d;
    logic [DATA_W-1:0] h_data_q,  h_data_d;
    logic              s_valid_q, s_valid_d;
    logic [CTRL_W-1:0] s_ctrl_q,  s_ctrl_d;
    logic [DATA_W-1:0] s_data_q,  s_data_d;
    logic [CNT_W-1:0]  stall_q,   stall_d;

    logic accept;
    logic consume;

    // in_ready comes straight from the skid flop, so there is no ready path back upstream.
    assign accept  = pipe_if.in_valid & ~s_valid_q;
    assign consume = h_valid_q & pipe_if.out_ready;

    always_comb begin
        h_valid_d = h_valid_q;
        h_ctrl_d  = h_ctrl_q;
        h_data_d  = h_data_q;
        s_valid_d = s_valid_q;
        s_ctrl_d  = s_ctrl_q;
        s_data_d  = s_data_q;
        if (pipe_if.flush) begin
            h_valid_d = 1'b0;
            s_valid_d = 1'b0;
        end else if (!h_valid_q) begin
            if (accept) begin
                h_valid_d = 1'b1;
                h_ctrl_d  = pipe_if.in_ctrl;
                h_data_d  = pipe_if.in_data;
            end
        end else if (consume) begin
            if (s_valid_q) begin
                h_ctrl_d  = s_ctrl_q;
                h_data_d  = s_data_q;
                s_valid_d = 1'b0;
            end else if (accept) begin
                h_ctrl_d  = pipe_if.in_ctrl;
                h_data_d  = pipe_if.in_data;
            end else begin
                h_valid_d = 1'b0;
            end
        end else if (accept) begin
            s_valid_d = 1'b1;
            s_ctrl_d  = pipe_if.in_ctrl;
            s_data_d  = pipe_if.in_data;
        end
    end

    always_comb begin
        stall_d = stall_q;
        if (h_valid_q && !pipe_if.out_ready && !pipe_if.flush && stall_q != CNT_MAX) begin
            stall_d = stall_q + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            h_valid_q <= 1'b0;
            h_ctrl_q  <= '0;
            h_data_q  <= '0;
            s_valid_q <= 1'b0;
            s_ctrl_q  <= '0;
            s_data_q  <= '0;
            stall_q   <= '0;
        end else begin
            h_valid_q <= h_valid_d;
            h_ctrl_q  <= h_ctrl_d;
            h_data_q  <= h_data_d;
            s_valid_q <= s_valid_d;
            s_ctrl_q  <= s_ctrl_d;
            s_data_q  <= s_data_d;
            stall_q   <= stall_d;
        end
    end

    // A bubble must never present live control bits such as memWrite or regWrite.
    assign pipe_if.out_valid = h_valid_q;
    assign pipe_if.in_ready  = ~s_valid_q;
    assign pipe_if.out_ctrl  = h_ctrl_q & {CTRL_W{h_valid_q}};
    assign pipe_if.out_data  = h_data_q;
    assign pipe_if.occupancy = {1'b0, h_valid_q} + {1'b0, s_valid_q};
    assign pipe_if.stall_cnt = stall_q;
endmodule

// File: tb/tb_exmem_skid_stage.sv
// Bench for exmem_skid_stage: directed scenarios with literal expectations plus a
// randomized run checked every cycle against a FIFO-queue model of the stage.
module tb_exmem_skid_stage;
  localparam int CTRL_W = 6;
  localparam int DATA_W = 262;
  localparam int CNT_W  = 3;
  localparam int EW     = CTRL_W + DATA_W;
  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  logic clk;
  logic reset;

  exmem_skid_stage_if #(.CTRL_W(CTRL_W), .DATA_W(DATA_W), .CNT_W(CNT_W)) bus ();

  exmem_skid_stage #(.CTRL_W(CTRL_W), .DATA_W(DATA_W), .CNT_W(CNT_W)) dut (
    .clk     (clk),
    .reset   (reset),
    .pipe_if (bus)
  );

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------- scoreboard ----------------
  logic [EW-1:0]     exp_q[$];
  logic [DATA_W-1:0] m_data;
  logic [CNT_W-1:0]  m_cnt;
  logic              m_took;
  int                n_cmp;
  int                n_bad;
  logic              chk_en;

  task automatic check(input string name, input logic [299:0] act, input logic [299:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  initial begin
    exp_q.delete();
    m_data = '0;
    m_cnt  = '0;
    m_took = 1'b0;
  end

  // Model: the stage is a FIFO of depth 2; entries leave from the front, enter at the back.
  always @(posedge clk) begin
    int sz;
    sz = exp_q.size();
    m_took = 1'b0;
    if (reset) begin
      exp_q.delete();
      m_data = '0;
      m_cnt  = '0;
      m_took = 1'b1;
    end else if (bus.flush) begin
      exp_q.delete();
      m_took = 1'b1;
    end else begin
      if (sz > 0 && !bus.out_ready && m_cnt != CNT_MAX) m_cnt = m_cnt + 1'b1;
      if (sz > 0 && bus.out_ready) void'(exp_q.pop_front());
      if (bus.in_valid && sz < 2) begin
        exp_q.push_back({bus.in_ctrl, bus.in_data});
        m_took = 1'b1;
      end
      if (exp_q.size() > 0) m_data = exp_q[0][DATA_W-1:0];
    end
  end

  always @(negedge clk) begin
    if (chk_en) begin
      logic [EW-1:0] head;
      logic [CTRL_W-1:0] ectrl;
      head  = (exp_q.size() > 0) ? exp_q[0] : '0;
      ectrl = (exp_q.size() > 0) ? head[EW-1:DATA_W] : '0;
      check("m_out_valid", 300'(bus.out_valid), 300'(exp_q.size() > 0));
      check("m_in_ready",  300'(bus.in_ready),  300'(exp_q.size() < 2));
      check("m_occupancy", 300'(bus.occupancy), 300'(exp_q.size()));
      check("m_out_ctrl",  300'(bus.out_ctrl),  300'(ectrl));
      check("m_out_data",  300'(bus.out_data),  300'(m_data));
      check("m_stall_cnt", 300'(bus.stall_cnt), 300'(m_cnt));
    end
  end

  // ---------------- driver tasks ----------------
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic v, input logic [CTRL_W-1:0] c, input logic [DATA_W-1:0] d);
    bus.in_valid = v;
    bus.in_ctrl  = c;
    bus.in_data  = d;
  endtask

  function automatic logic [DATA_W-1:0] rand_data();
    logic [DATA_W-1:0] d;
    d = '0;
    for (int k = 0; k < 9; k++) d = {d[DATA_W-33:0], 32'($urandom())};
    return d;
  endfunction

  logic [DATA_W-1:0] da, db, dc;

  initial begin
    n_cmp  = 0;
    n_bad  = 0;
    chk_en = 1'b0;
    reset  = 1'b1;
    bus.flush     = 1'b0;
    bus.out_ready = 1'b0;
    drive(1'b0, '0, '0);
    step();
    step();
    chk_en = 1'b1;
    reset  = 1'b0;
    check("rst_out_valid", 300'(bus.out_valid), 300'(0));
    check("rst_in_ready",  300'(bus.in_ready),  300'(1));
    check("rst_occupancy", 300'(bus.occupancy), 300'(0));
    check("rst_out_data",  300'(bus.out_data),  300'(0));
    check("rst_stall_cnt", 300'(bus.stall_cnt), 300'(0));

    // Streaming A, B, C with out_ready high
    da = rand_data(); db = rand_data(); dc = rand_data();
    bus.out_ready = 1'b1;
    drive(1'b1, 6'h21, da); step();
    check("stream_a_valid", 300'(bus.out_valid), 300'(1));
    check("stream_a_data",  300'(bus.out_data),  300'(da));
    check("stream_a_ctrl",  300'(bus.out_ctrl),  300'(6'h21));
    drive(1'b1, 6'h21, db); step();
    check("stream_b_data",  300'(bus.out_data),  300'(db));
    check("stream_b_ready", 300'(bus.in_ready),  300'(1));
    drive(1'b1, 6'h21, dc); step();
    check("stream_c_data",  300'(bus.out_data),  300'(dc));
    check("stream_c_ready", 300'(bus.in_ready),  300'(1));
    drive(1'b0, '0, '0); step();
    check("stream_end_valid", 300'(bus.out_valid), 300'(0));

    // Stall fills the skid, then drains in order
    da = rand_data(); db = rand_data();
    bus.out_ready = 1'b0;
    drive(1'b1, 6'h05, da); step();
    check("stall_occ1",  300'(bus.occupancy), 300'(1));
    drive(1'b1, 6'h0a, db); step();
    check("stall_occ2",  300'(bus.occupancy), 300'(2));
    check("stall_ready", 300'(bus.in_ready),  300'(0));
    check("stall_head",  300'(bus.out_data),  300'(da));
    drive(1'b0, '0, '0);
    bus.out_ready = 1'b1; step();
    check("drain_b_data",  300'(bus.out_data),  300'(db));
    check("drain_b_ctrl",  300'(bus.out_ctrl),  300'(6'h0a));
    check("drain_ready",   300'(bus.in_ready),  300'(1));
    step();
    check("drain_empty",   300'(bus.out_valid), 300'(0));

    // Bubble gating: all-ones control with no valid input
    drive(1'b0, '1, rand_data());
    for (int i = 0; i < 4; i++) begin
      step();
      check("bubble_ctrl",  300'(bus.out_ctrl),  300'(0));
      check("bubble_valid", 300'(bus.out_valid), 300'(0));
      check("bubble_data",  300'(bus.out_data),  300'(db));
    end

    // Flush with two entries held and C on the input
    da = rand_data(); db = rand_data(); dc = rand_data();
    bus.out_ready = 1'b0;
    drive(1'b1, 6'h11, da); step();
    drive(1'b1, 6'h12, db); step();
    drive(1'b1, 6'h13, dc);
    bus.flush = 1'b1; step();
    bus.flush = 1'b0;
    check("flush_valid", 300'(bus.out_valid), 300'(0));
    check("flush_occ",   300'(bus.occupancy), 300'(0));
    check("flush_ready", 300'(bus.in_ready),  300'(1));
    check("flush_data",  300'(bus.out_data),  300'(da));
    drive(1'b0, '0, '0);
    bus.out_ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      step();
      check("flush_no_c", 300'(bus.out_valid), 300'(0));
    end

    // Reset with two entries held
    bus.out_ready = 1'b0;
    drive(1'b1, 6'h3f, rand_data()); step();
    drive(1'b1, 6'h3e, rand_data()); step();
    drive(1'b0, '0, '0);
    reset = 1'b1; step();
    reset = 1'b0;
    check("mrst_valid", 300'(bus.out_valid), 300'(0));
    check("mrst_ctrl",  300'(bus.out_ctrl),  300'(0));
    check("mrst_data",  300'(bus.out_data),  300'(0));
    check("mrst_ready", 300'(bus.in_ready),  300'(1));
    check("mrst_occ",   300'(bus.occupancy), 300'(0));
    check("mrst_cnt",   300'(bus.stall_cnt), 300'(0));

    // Counter saturation at 7 with CNT_W=3
    drive(1'b1, 6'h01, rand_data()); step();
    drive(1'b0, '0, '0);
    for (int i = 1; i <= 10; i++) begin
      step();
      check("sat_cnt", 300'(bus.stall_cnt), 300'((i < 7) ? i : 7));
    end

    // Randomized traffic; a not-yet-taken input is held stable
    for (int cyc = 0; cyc < 3000; cyc++) begin
      if (!(bus.in_valid && !m_took)) begin
        drive(1'($urandom_range(0, 1)), CTRL_W'($urandom()), rand_data());
      end
      bus.out_ready = ($urandom_range(0, 3) != 0) ? 1'b1 : 1'b0;
      if (cyc % 200 < 60) bus.out_ready = ($urandom_range(0, 3) == 0);
      bus.flush = ($urandom_range(0, 31) == 0);
      reset     = ($urandom_range(0, 255) == 0);
      step();
    end
    reset = 1'b0;
    bus.flush = 1'b0;
    step();

    chk_en = 1'b0;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
